packet_generator: RTL and testbench
===================================

# packet_generator

Transmit-side counterpart of the packet cycle monitor: emits a burst of AXI-Stream packets of a programmed length in clock cycles, each terminated by tlast. It sits on the TX stream path as a traffic source for link bring-up and loopback tests. A monitor on the far end reports the same 8-bit cycle count that was programmed here. Each beat carries a self-describing pattern so the receiver can check order and packet boundaries.

## Interface
- DW, 512, stream data width in bits; must be a multiple of 32
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a burst; ignored while busy
- packet_cycles  in  8  beats per packet; 0 means 256
- packet_count  in  16  packets per burst; 0 means no packets
- gap_cycles  in  8  idle cycles between packets (present only with PKTGEN_GAP_EN)
- busy  out  1  high from start acceptance until the cycle done pulses
- done  out  1  one-cycle pulse at burst completion
- packets_sent  out  16  packets completed in the current or last burst
- axis_tdata  out  DW  stream data
- axis_tlast  out  1  last beat of packet
- axis_tvalid  out  1  stream valid
- axis_tready  in  1  stream ready

## Operation
- States: IDLE, SEND, GAP (GAP exists only with PKTGEN_GAP_EN).
- IDLE: start=1 latches packet_cycles, packet_count, gap_cycles; clears beat_idx, pkt_idx, packets_sent; sets busy.
  - If latched packet_count=0: next state IDLE, done pulses; busy high for exactly one cycle; no beats emitted.
  - Otherwise: next state SEND.
- SEND: axis_tvalid=1. A beat transfers when axis_tvalid & axis_tready.
  - Beat index beat_idx is 8 bits, 0 to (packet_cycles-1) mod 256; axis_tlast=1 when beat_idx+1 equals latched packet_cycles (8-bit compare, so 0 gives 256 beats).
  - axis_tdata: each 32-bit lane = {pkt_idx[15:0], 8'hA5, beat_idx[7:0]}; all lanes identical.
  - On a tlast transfer: packets_sent++, pkt_idx++, beat_idx=0. If packets_sent+1 equals packet_count: go IDLE, pulse done, drop busy. Else go GAP if gap nonzero, else stay in SEND.
- GAP: axis_tvalid=0 for exactly latched gap_cycles cycles, then SEND.
- start is ignored in every state other than IDLE. This includes the cycle in which done pulses.
- AXI rule: once axis_tvalid rises, axis_tvalid, axis_tdata, and axis_tlast hold until a transfer. axis_tvalid is never dependent on axis_tready.

## Timing
- Reset (async assert) forces IDLE and all outputs to 0: busy, done, packets_sent, axis_tdata, axis_tlast, axis_tvalid. Reset mid-packet truncates the packet with no tlast; this is acceptable.
- start sampled at cycle N; axis_tvalid=1 at N+1 with beat 0 of packet 0.
- With tready held high and no gap: one beat per cycle. Packets are back-to-back, and axis_tvalid never drops within a burst.
- Final tlast transfer at cycle M: at M+1, done=1, busy=0, axis_tvalid=0, and packets_sent equals packet_count.
- Earliest next start is accepted at M+1 or later, once done has pulsed. A start coinciding with the done cycle is ignored.
- tready low stalls; beat_idx, pkt_idx, and the gap counter do not advance during a stall in SEND.
- packets_sent holds its final value until the next accepted start.

## Configuration
- PKTGEN_GAP_EN defined: gap_cycles port and GAP state exist. Idle time between packets equals the latched gap_cycles; no gap follows the final packet.
- Not defined: gap_cycles port absent, no GAP state, and packets are always back-to-back.

## Test plan
- Reset, then start with cycles=4, count=3, tready=1 -> 12 consecutive beats; tlast on beats 3, 7, 11; lane0 of beat 5 = 0x0001A501; done at start+13; packets_sent=3.
- cycles=0, count=1 -> 256 beats; tlast only on beat_idx 0xFF; far-end cycle monitor reads 0.
- count=0 -> done pulses the cycle after start, busy high one cycle, axis_tvalid never asserts.
- cycles=2, count=2, tready toggling 1,0,1,0 -> tdata and tlast stable across every stall; 4 transfers total; pattern unchanged from the tready=1 case.
- PKTGEN_GAP_EN with gap=3, cycles=1, count=3 -> tvalid high, 3 low, high, 3 low, high; then done.
- resetn asserted mid-packet -> tvalid, busy, and packets_sent are 0 immediately. A later start runs a clean burst beginning at pkt_idx 0.

Source files
------------

// File: rtl/packet_generator.sv
// packet_generator: AXI-Stream traffic source for link bring-up and loopback.
// Emits a burst of packet_count packets, each packet_cycles beats long and ended by tlast.
// Every 32-bit lane of a beat carries {pkt_idx[15:0], 8'hA5, beat_idx[7:0]}, so the
// far end can check both beat order and packet boundaries.
//
// Optional feature macro: PKTGEN_GAP_EN
//   When defined, this adds the gap_cycles port and a GAP state that inserts idle
//   cycles between packets.
//
// Ports:
//   clk, resetn    rising-edge clock, asynchronous active-low reset
//   start          one-cycle burst request; taken only in IDLE, never while done pulses
//   packet_cycles  beats per packet (0 means 256)
//   packet_count   packets per burst (0 means an empty burst that only pulses done)
//   gap_cycles     idle cycles between packets (PKTGEN_GAP_EN only)
//   busy           high from start acceptance until the done cycle
//   done           one-cycle pulse at burst completion
//   packets_sent   packets completed in the current or last burst
//   axis_*         AXI-Stream master (tdata/tlast/tvalid out, tready in)
module packet_generator #(
  parameter int unsigned DW = 512  // must be a multiple of 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [7:0]    packet_cycles,
  input  logic [15:0]   packet_count,
`ifdef PKTGEN_GAP_EN
  input  logic [7:0]    gap_cycles,
`endif
  output logic          busy,
  output logic          done,
  output logic [15:0]   packets_sent,
  output logic [DW-1:0] axis_tdata,
  output logic          axis_tlast,
  output logic          axis_tvalid,
  input  logic          axis_tready
);

  localparam int unsigned Lanes = DW / 32;

`ifdef PKTGEN_GAP_EN
  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;
`else
  typedef enum logic [0:0] {StIdle, StSend} state_e;
`endif

  state_e       state_q, state_d;
  logic [7:0]   cycles_q, cycles_d;
  logic [15:0]  count_q, count_d;
  logic [7:0]   beat_idx_q, beat_idx_d;
  logic [15:0]  pkt_idx_q, pkt_idx_d;
  logic [15:0]  sent_q, sent_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef PKTGEN_GAP_EN
  logic [7:0]   gap_q, gap_d;
  logic [7:0]   gap_cnt_q, gap_cnt_d;
`endif

  logic         accept;
  logic         fire;
  logic         last_beat;
  logic [7:0]   beat_inc;
  logic [31:0]  lane;

  // Start is refused during the done pulse so a burst always reports completion first.
  assign accept    = (state_q == StIdle) && start && !done_q;
  assign fire      = axis_tvalid && axis_tready;
  assign beat_inc  = beat_idx_q + 8'd1;
  // 8-bit wrap makes packet_cycles == 0 mean a 256-beat packet.
  assign last_beat = (beat_inc == cycles_q);
  assign lane      = {pkt_idx_q, 8'hA5, beat_idx_q};

  // Stream outputs depend only on registered state, so they hold steady across stalls
  // and never depend on tready. Data is zeroed outside SEND to keep reset outputs clean.
  always_comb begin
    axis_tvalid = (state_q == StSend);
    axis_tlast  = axis_tvalid && last_beat;
    axis_tdata  = axis_tvalid ? {Lanes{lane}} : '0;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign packets_sent = sent_q;

  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    count_d    = count_q;
    beat_idx_d = beat_idx_q;
    pkt_idx_d  = pkt_idx_q;
    sent_d     = sent_q;
    done_d     = 1'b0;
`ifdef PKTGEN_GAP_EN
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (accept) begin
          cycles_d   = packet_cycles;
          count_d    = packet_count;
          beat_idx_d = 8'd0;
          pkt_idx_d  = 16'd0;
          sent_d     = 16'd0;
`ifdef PKTGEN_GAP_EN
          gap_d      = gap_cycles;
`endif
          if (packet_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StSend;
          end
        end
      end

      StSend: begin
        if (fire) begin
          if (last_beat) begin
            beat_idx_d = 8'd0;
            pkt_idx_d  = pkt_idx_q + 16'd1;
            sent_d     = sent_q + 16'd1;
            if (sent_q + 16'd1 == count_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
`ifdef PKTGEN_GAP_EN
            end else if (gap_q != 8'd0) begin
              state_d   = StGap;
              gap_cnt_d = gap_q;
`endif
            end
          end else begin
            beat_idx_d = beat_inc;
          end
        end
      end

`ifdef PKTGEN_GAP_EN
      // Counts down from gap_q; the cycle holding 1 is the last idle cycle.
      StGap: begin
        if (gap_cnt_q <= 8'd1) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    // An empty burst still shows busy for the single cycle its done pulses.
    busy_d = (state_d != StIdle) || (accept && (packet_count == 16'd0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cycles_q   <= 8'd0;
      count_q    <= 16'd0;
      beat_idx_q <= 8'd0;
      pkt_idx_q  <= 16'd0;
      sent_q     <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PKTGEN_GAP_EN
      gap_q      <= 8'd0;
      gap_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      count_q    <= count_d;
      beat_idx_q <= beat_idx_d;
      pkt_idx_q  <= pkt_idx_d;
      sent_q     <= sent_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PKTGEN_GAP_EN
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_packet_generator.sv
// tb_packet_generator: directed bench for packet_generator with a beat scoreboard.
// Expected beats are queued when a burst is started and checked as the DUT transfers them.
module tb_packet_generator;

  localparam int unsigned DW = 512;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [7:0]    packet_cycles;
  logic [15:0]   packet_count;
`ifdef PKTGEN_GAP_EN
  logic [7:0]    gap_cycles;
`endif
  logic          busy;
  logic          done;
  logic [15:0]   packets_sent;
  logic [DW-1:0] axis_tdata;
  logic          axis_tlast;
  logic          axis_tvalid;
  logic          axis_tready;

  int n_checks = 0;
  int n_pass   = 0;

  // {tlast, lane value}
  logic [32:0] exp_q[$];

  packet_generator #(.DW(DW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .packet_cycles (packet_cycles),
    .packet_count  (packet_count),
`ifdef PKTGEN_GAP_EN
    .gap_cycles    (gap_cycles),
`endif
    .busy          (busy),
    .done          (done),
    .packets_sent  (packets_sent),
    .axis_tdata    (axis_tdata),
    .axis_tlast    (axis_tlast),
    .axis_tvalid   (axis_tvalid),
    .axis_tready   (axis_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_burst(input int cycles, input int count);
    int nb;
    logic [15:0] p16;
    logic [7:0]  b8;
    nb = (cycles == 0) ? 256 : cycles;
    for (int p = 0; p < count; p++) begin
      for (int b = 0; b < nb; b++) begin
        p16 = p[15:0];
        b8  = b[7:0];
        exp_q.push_back({(b == nb - 1), p16, 8'hA5, b8});
      end
    end
  endtask

  // Called just after a posedge; returns just after the posedge that sampled start.
  task automatic run_start(input int cycles, input int count);
    push_burst(cycles, count);
    packet_cycles = cycles[7:0];
    packet_count  = count[15:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, input bit toggle);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (toggle) axis_tready = ~axis_tready;
    end
    check("done_seen", {{(DW-1){1'b0}}, done}, 1);
  endtask

  // Scoreboard and AXI hold checker, sampled mid-cycle.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;
  logic          last_prev;
  logic [32:0]   e;

  always @(negedge clk) begin
    if (!resetn) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_tvalid", {{(DW-1){1'b0}}, axis_tvalid}, 1);
        check("hold_tdata", axis_tdata, data_prev);
        check("hold_tlast", {{(DW-1){1'b0}}, axis_tlast}, {{(DW-1){1'b0}}, last_prev});
      end
      if (axis_tvalid && axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_tdata", axis_tdata, {(DW/32){e[31:0]}});
          check("beat_tlast", {{(DW-1){1'b0}}, axis_tlast}, {{(DW-1){1'b0}}, e[32]});
        end
      end
      stall_prev <= axis_tvalid && !axis_tready;
      data_prev  <= axis_tdata;
      last_prev  <= axis_tlast;
    end
  end

  int cyc;

  initial begin
    resetn        = 1'b0;
    start         = 1'b0;
    packet_cycles = 8'd0;
    packet_count  = 16'd0;
`ifdef PKTGEN_GAP_EN
    gap_cycles    = 8'd0;
`endif
    axis_tready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {{(DW-1){1'b0}}, busy}, 0);
    check("rst_done", {{(DW-1){1'b0}}, done}, 0);
    check("rst_sent", {{(DW-16){1'b0}}, packets_sent}, 0);
    check("rst_tvalid", {{(DW-1){1'b0}}, axis_tvalid}, 0);
    check("rst_tlast", {{(DW-1){1'b0}}, axis_tlast}, 0);
    check("rst_tdata", axis_tdata, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 3 packets of 4 beats, back-to-back.
    run_start(4, 3);
    check("t1_tvalid_n1", {{(DW-1){1'b0}}, axis_tvalid}, 1);
    check("t1_busy", {{(DW-1){1'b0}}, busy}, 1);
    check("t1_beat0", axis_tdata, {(DW/32){32'h0000A500}});
    wait_done(cyc, 1'b0);
    check("t1_done_cycle", cyc, 12);
    check("t1_sent", {{(DW-16){1'b0}}, packets_sent}, 3);
    check("t1_busy_at_done", {{(DW-1){1'b0}}, busy}, 0);
    check("t1_tvalid_at_done", {{(DW-1){1'b0}}, axis_tvalid}, 0);
    check("t1_queue_empty", exp_q.size(), 0);
    // Start during the done pulse must be ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t1_ign_busy", {{(DW-1){1'b0}}, busy}, 0);
    check("t1_ign_tvalid", {{(DW-1){1'b0}}, axis_tvalid}, 0);
    check("t1_sent_hold", {{(DW-16){1'b0}}, packets_sent}, 3);
    @(posedge clk); #1;

    // Empty burst.
    run_start(4, 0);
    check("t2_done", {{(DW-1){1'b0}}, done}, 1);
    check("t2_busy", {{(DW-1){1'b0}}, busy}, 1);
    check("t2_tvalid", {{(DW-1){1'b0}}, axis_tvalid}, 0);
    check("t2_sent", {{(DW-16){1'b0}}, packets_sent}, 0);
    @(posedge clk); #1;
    check("t2_done_drop", {{(DW-1){1'b0}}, done}, 0);
    check("t2_busy_drop", {{(DW-1){1'b0}}, busy}, 0);
    @(posedge clk); #1;

    // 256-beat packet.
    run_start(0, 1);
    wait_done(cyc, 1'b0);
    check("t3_done_cycle", cyc, 256);
    check("t3_sent", {{(DW-16){1'b0}}, packets_sent}, 1);
    @(posedge clk); #1;

    // Backpressure with tready toggling.
    run_start(2, 2);
    wait_done(cyc, 1'b1);
    axis_tready = 1'b1;
    check("t4_sent", {{(DW-16){1'b0}}, packets_sent}, 2);
    check("t4_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;

`ifdef PKTGEN_GAP_EN
    // Gap of 3 idle cycles between 1-beat packets, none after the last.
    gap_cycles = 8'd3;
    run_start(1, 3);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t5_gap_tvalid_%0d", i), {{(DW-1){1'b0}}, axis_tvalid},
            {{(DW-1){1'b0}}, ((i % 4) == 0)});
      @(posedge clk); #1;
    end
    check("t5_done", {{(DW-1){1'b0}}, done}, 1);
    check("t5_sent", {{(DW-16){1'b0}}, packets_sent}, 3);
    gap_cycles = 8'd0;
    @(posedge clk); #1;
`endif

    // Reset in the middle of a packet, then a clean burst.
    run_start(8, 2);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("t6_tvalid", {{(DW-1){1'b0}}, axis_tvalid}, 0);
    check("t6_busy", {{(DW-1){1'b0}}, busy}, 0);
    check("t6_sent", {{(DW-16){1'b0}}, packets_sent}, 0);
    check("t6_tdata", axis_tdata, 0);
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_start(2, 1);
    check("t6_restart_beat0", axis_tdata, {(DW/32){32'h0000A500}});
    wait_done(cyc, 1'b0);
    check("t6_restart_cycle", cyc, 2);
    check("t6_restart_sent", {{(DW-16){1'b0}}, packets_sent}, 1);
    check("t6_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
